// File: rtl/cpu_run_monitor.sv
// Run controller and output monitor for the pipelined CPU core: reset sequencing, run timing and output-change capture.
// Optional per-capture cycle stamps are enabled by defining MON_TIMESTAMP_EN.
module cpu_run_monitor #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int RESET_CYCLES = 8,
    parameter int RUN_CYCLES   = 1024,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       master_reset,
    input  logic                       start,
    output logic                       cpu_reset,
    input  logic [DATA_W-1:0]          cpu_out,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     n_captured,
    output logic [CNT_W-1:0]           cycle_count,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout
`ifdef MON_TIMESTAMP_EN
    ,
    output logic [CNT_W-1:0]           rd_stamp
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [NW-1:0]    FULL_N    = NW'(DEPTH);
    localparam logic [NW-1:0]    N_ONE     = NW'(1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [NW-1:0]       n_q, n_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, done_q, cpu_reset_q;
    logic [DATA_W-1:0]   rd_data_q;

    logic                cap_s;
    logic                wr_en_s;
    logic [NW-1:0]       n_inc_s;
    logic [CNT_W-1:0]    cur_cnt_s;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == CNT_MAX) begin
            sat_inc = val;
        end else begin
            sat_inc = val + CNT_ONE;
        end
    endfunction

    // Next-state and counter update for the run sequencer
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        prev_d    = prev_q;
        timeout_d = timeout_q;
        cap_s     = 1'b0;
        n_inc_s   = n_q;
        cur_cnt_s = sat_inc(cnt_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_HOLD;
                    hold_d    = '0;
                    n_d       = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end else begin
                    state_d   = state_q;
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d  = hold_q + HOLD_ONE;
                end
            end
            ST_RUN: begin
                // cnt_q is still zero only during the first run cycle, which always captures
                cnt_d   = cur_cnt_s;
                prev_d  = cpu_out;
                cap_s   = (cnt_q == '0) || (cpu_out != prev_q);
                n_inc_s = cap_s ? (n_q + N_ONE) : n_q;
                n_d     = n_inc_s;
                if (n_inc_s == FULL_N) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b0;
                end else if (cur_cnt_s == RUN_LAST) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    state_d   = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wr_en_s = cap_s & master_reset;

    // State, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (!master_reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            prev_q      <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            timeout_q   <= timeout_d;
            busy_q      <= (state_d == ST_HOLD) || (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
            cpu_reset_q <= (state_d != ST_RUN);
        end
    end

    // Capture buffer write; contents deliberately survive master_reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[n_q[AW-1:0]] <= cpu_out;
        end
    end

    // Registered read port, returns pre-write data on a same-address collision
    always_ff @(posedge clk) begin
        if (!master_reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

`ifdef MON_TIMESTAMP_EN
    logic [CNT_W-1:0] stamp_q [DEPTH];
    logic [CNT_W-1:0] rd_stamp_q;

    // Stamp buffer write alongside each data capture
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            stamp_q[n_q[AW-1:0]] <= cur_cnt_s;
        end
    end

    // Registered stamp read, aligned with rd_data
    always_ff @(posedge clk) begin
        if (!master_reset) begin
            rd_stamp_q <= '0;
        end else begin
            rd_stamp_q <= stamp_q[rd_addr];
        end
    end

    assign rd_stamp = rd_stamp_q;
`endif

    assign cpu_reset   = cpu_reset_q;
    assign rd_data     = rd_data_q;
    assign n_captured  = n_q;
    assign cycle_count = cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized self-checking bench for cpu_run_monitor against a list-based run model.
module tb_cpu_run_monitor;

    localparam int DATA_W       = 8;
    localparam int DEPTH        = 16;
    localparam int RESET_CYCLES = 8;
    localparam int RUN_CYCLES   = 1024;
    localparam int CNT_W        = 16;

    logic              clk = 1'b0;
    logic              master_reset;
    logic              start;
    logic              cpu_reset;
    logic [DATA_W-1:0] cpu_out;
    logic [3:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [4:0]        n_captured;
    logic [CNT_W-1:0]  cycle_count;
    logic              busy, done, timeout;
`ifdef MON_TIMESTAMP_EN
    logic [CNT_W-1:0]  rd_stamp;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] v [0:RUN_CYCLES];
    logic [DATA_W-1:0] exp_data [$];
    int                exp_stamp [$];
    int                exp_end;
    bit                exp_to;

    cpu_run_monitor #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_CYCLES(RESET_CYCLES),
        .RUN_CYCLES(RUN_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .master_reset(master_reset), .start(start), .cpu_reset(cpu_reset),
        .cpu_out(cpu_out), .rd_addr(rd_addr), .rd_data(rd_data), .n_captured(n_captured),
        .cycle_count(cycle_count), .busy(busy), .done(done), .timeout(timeout)
`ifdef MON_TIMESTAMP_EN
        , .rd_stamp(rd_stamp)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Captured list: every run cycle whose value differs from the one before (first always counts)
    task automatic model(input int limit);
        exp_data.delete();
        exp_stamp.delete();
        exp_end = 0;
        exp_to  = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            if (k == 1 || v[k] != v[k-1]) begin
                exp_data.push_back(v[k]);
                exp_stamp.push_back(k);
            end
            if (exp_data.size() == DEPTH) begin
                exp_end = k; exp_to = 1'b0; break;
            end
            if (k == RUN_CYCLES) begin
                exp_end = k; exp_to = 1'b1; break;
            end
        end
    endtask

    task automatic gen_random(input int p);
        v[0] = 8'h00;
        for (int k = 1; k <= RUN_CYCLES; k++) begin
            if (k == 1 || $urandom_range(p - 1) == 0) v[k] = 8'($urandom);
            else                                      v[k] = v[k-1];
        end
    endtask

    task automatic readback(input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = 4'(i);
            tick();
            check_eq("rd_data", 32'(rd_data), 32'(exp_data[i]));
`ifdef MON_TIMESTAMP_EN
            check_eq("rd_stamp", 32'(rd_stamp), 32'(exp_stamp[i]));
`endif
        end
    endtask

    // One full start/hold/run sequence; rst_at > 0 pulls master_reset during that run cycle
    task automatic do_run(input int rst_at);
        int  k;
        bit  fin;
        model(rst_at > 0 ? rst_at - 1 : RUN_CYCLES);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("hold_busy", 32'(busy), 32'd1);
        check_eq("hold_done", 32'(done), 32'd0);
        check_eq("hold_ncap", 32'(n_captured), 32'd0);
        check_eq("hold_cnt", 32'(cycle_count), 32'd0);
        check_eq("hold_tmo", 32'(timeout), 32'd0);
        check_eq("hold_cpurst", 32'(cpu_reset), 32'd1);
        for (int h = 1; h < RESET_CYCLES; h++) begin
            tick();
            check_eq("hold_cpurst", 32'(cpu_reset), 32'd1);
        end
        tick();
        check_eq("run_cpurst", 32'(cpu_reset), 32'd0);
        check_eq("run_busy", 32'(busy), 32'd1);
        k = 0;
        fin = 1'b0;
        while (!fin) begin
            k++;
            cpu_out = v[k];
            start   = (k == 3);
            if (k == rst_at) master_reset = 1'b0;
            tick();
            start = 1'b0;
            if (k == rst_at) begin
                master_reset = 1'b1;
                check_eq("mrst_cpurst", 32'(cpu_reset), 32'd1);
                check_eq("mrst_busy", 32'(busy), 32'd0);
                check_eq("mrst_done", 32'(done), 32'd0);
                check_eq("mrst_ncap", 32'(n_captured), 32'd0);
                check_eq("mrst_cnt", 32'(cycle_count), 32'd0);
                readback(exp_data.size());
                return;
            end
            if (done) begin
                fin = 1'b1;
            end else if (k >= RUN_CYCLES + 4) begin
                check_eq("run_done", 32'(done), 32'd1);
                fin = 1'b1;
            end
        end
        check_eq("end_cycle", 32'(k), 32'(exp_end));
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_cpurst", 32'(cpu_reset), 32'd1);
        check_eq("done_tmo", 32'(timeout), 32'(exp_to));
        check_eq("done_ncap", 32'(n_captured), 32'(exp_data.size()));
        check_eq("done_cnt", 32'(cycle_count), 32'(exp_end));
        for (int i = 0; i < 2; i++) begin
            cpu_out = 8'($urandom);
            tick();
        end
        check_eq("frozen_cnt", 32'(cycle_count), 32'(exp_end));
        check_eq("frozen_ncap", 32'(n_captured), 32'(exp_data.size()));
        check_eq("frozen_done", 32'(done), 32'd1);
        readback(exp_data.size());
    endtask

    initial begin
        master_reset = 1'b0;
        start        = 1'b0;
        cpu_out      = 8'h00;
        rd_addr      = 4'd0;
        for (int i = 0; i < 3; i++) tick();
        check_eq("rst_cpurst", 32'(cpu_reset), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ncap", 32'(n_captured), 32'd0);
        check_eq("rst_cnt", 32'(cycle_count), 32'd0);
        check_eq("rst_tmo", 32'(timeout), 32'd0);
        check_eq("rst_rdata", 32'(rd_data), 32'd0);
        master_reset = 1'b1;
        tick();
        check_eq("idle_cpurst", 32'(cpu_reset), 32'd1);

        // Stepped pattern then static: four captures, then timeout
        v[0] = 8'h00; v[1] = 8'h00; v[2] = 8'h05; v[3] = 8'h05; v[4] = 8'hA3;
        for (int k = 5; k <= RUN_CYCLES; k++) v[k] = 8'hFF;
        do_run(0);

        // Static output: one capture, timeout at the run limit
        for (int k = 0; k <= RUN_CYCLES; k++) v[k] = 8'h11;
        do_run(0);

        // Toggling every cycle fills the buffer
        for (int k = 0; k <= RUN_CYCLES; k++) v[k] = k[0] ? 8'hAA : 8'h55;
        do_run(0);

        gen_random(2);
        do_run(0);
        gen_random(80);
        do_run(0);
        gen_random(4);
        do_run(0);

        // Slow-changing pattern interrupted by master_reset in run cycle 50
        v[0] = 8'h00;
        for (int k = 1; k <= RUN_CYCLES; k++) begin
            if (k % 7 == 1) v[k] = 8'($urandom);
            else            v[k] = v[k-1];
        end
        do_run(50);

        gen_random(3);
        do_run(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
